pixel_class_counter: RTL and testbench

//  Producer side of the per-neuron score path: streams one binarised image
//  (one pixel bit + weight-class code per beat) and counts active pixels per

---
 rtl/pixel_class_counter_if.sv | 34 +++
 rtl/pixel_class_counter.sv | 113 +++++++++++
 tb/tb_pixel_class_counter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pixel_class_counter_if.sv
`default_nettype none
// ============================================================================
//  Interface : pixel_class_counter_if
//  Purpose   : Beat stream carrying one binarised pixel and its weight-class
//              code per transfer, with a valid/ready handshake.
//  Signals   : in_valid  producer -> consumer  beat valid
//              in_ready  consumer -> producer  beat accepted when valid&ready
//              in_pixel  producer -> consumer  binarised pixel (1 = active)
//              in_class  producer -> consumer  weight class of this pixel
//  Revision  : 1.0  initial release
// ============================================================================
interface pixel_class_counter_if #(
  parameter int CLASS_W = 4
) ();
  logic               in_valid;
  logic               in_ready;
  logic               in_pixel;
  logic [CLASS_W-1:0] in_class;

  modport master (
    output in_valid,
    output in_pixel,
    output in_class,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_pixel,
    input  in_class,
    output in_ready
  );
endinterface
`default_nettype wire

// File: rtl/pixel_class_counter.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_class_counter
//  Purpose  : Streams one binarised image (one pixel + class code per beat)
//             and counts active pixels per weight class. Produces
//             NUM_CLASSES saturating counts for the weighted score adder and
//             a one-cycle done pulse once NUM_PIXELS beats have been accepted.
//  Ports    : clk     rising-edge clock
//             rst     asynchronous active-high reset
//             start   begin a new image (honoured in IDLE only)
//             beat    slave side of the pixel beat stream
//             counts  per-class counts, unpacked [0:NUM_CLASSES-1]
//             busy    high while counting an image
//             done    one-cycle pulse, counts are final
//  Revision : 1.0  initial release
// ============================================================================
module pixel_class_counter #(
  parameter int NUM_CLASSES = 13,
  parameter int CNT_W       = 8,
  parameter int CLASS_W     = 4,
  parameter int NUM_PIXELS  = 784
) (
  input  wire                        clk,
  input  wire                        rst,
  input  wire                        start,
  pixel_class_counter_if.slave       beat,
  output logic [CNT_W-1:0]           counts [0:NUM_CLASSES-1],
  output logic                       busy,
  output logic                       done
);

  localparam int IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] pix_idx;

  // Handshake is qualified by the registered ready, so acceptance only
  // happens in COUNT and there is no combinational valid->ready path.
  wire accept = beat.in_valid & beat.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pix_idx       <= '0;
      beat.in_ready <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        counts[c] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state         <= COUNT;
            pix_idx       <= '0;
            beat.in_ready <= 1'b1;
            busy          <= 1'b1;
            for (int c = 0; c < NUM_CLASSES; c++) begin
              counts[c] <= '0;
            end
          end
        end

        COUNT: begin
          if (accept) begin
            // Class codes outside 0..NUM_CLASSES-1 match no counter, so
            // zero-weight beats only advance the pixel index.
            for (int c = 0; c < NUM_CLASSES; c++) begin
              if (beat.in_pixel && (beat.in_class == CLASS_W'(c)) &&
                  (counts[c] != CNT_MAX)) begin
                counts[c] <= counts[c] + 1'b1;
              end
            end
            if (pix_idx == LAST_IDX) begin
              state         <= DONE;
              pix_idx       <= '0;
              beat.in_ready <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
            end else begin
              pix_idx <= pix_idx + 1'b1;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state         <= IDLE;
          pix_idx       <= '0;
          beat.in_ready <= 1'b0;
          busy          <= 1'b0;
          done          <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_class_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_class_counter
//  Purpose  : Self-checking bench for pixel_class_counter. A table of whole
//             images (pixel/class pattern, valid gaps, stray start pulses,
//             expected counts) plus hand sequences for reset and mid-image
//             abort.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pixel_class_counter;

  localparam int NC  = 13;
  localparam int NP  = 784;
  localparam int LIM = 4000;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] counts [0:NC-1];
  logic       busy;
  logic       done;

  pixel_class_counter_if #(.CLASS_W(4)) bif ();

  pixel_class_counter #(
    .NUM_CLASSES(NC),
    .CNT_W      (8),
    .CLASS_W    (4),
    .NUM_PIXELS (NP)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .beat  (bif.slave),
    .counts(counts),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]       pat;
    logic             gaps;
    logic             noise;
    logic [12:0][7:0] exp;
  } vec_t;

  vec_t vecs [6];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0][7:0] packed_counts();
    logic [12:0][7:0] p;
    for (int c = 0; c < NC; c++) p[c] = counts[c];
    return p;
  endfunction

  function automatic logic pix_of(input int pat, input int i);
    case (pat)
      0:       return 1'b0;
      2:       return (i < 300);
      4:       return (i % 2 == 1);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] cls_of(input int pat, input int i);
    case (pat)
      2:       return 4'd5;
      3:       return 4'(13 + (i % 3));
      4:       return 4'(i % 16);
      5:       return 4'd0;
      default: return 4'(i % 13);
    endcase
  endfunction

  // Runs one full image. Caller leaves the bench at a negedge in IDLE.
  task automatic run_image(input vec_t v, input int id);
    int n, cyc, early;
    logic acc, vld;
    string tag;
    tag = $sformatf("img%0d", id);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_clear"}, packed_counts(), '0);
    check({tag, "_busy_ready"}, {busy, bif.in_ready}, 2'b11);
    n = 0; cyc = 0; early = 0;
    while (n < NP && cyc < LIM) begin
      vld          = v.gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bif.in_valid = vld;
      bif.in_pixel = pix_of(int'(v.pat), n);
      bif.in_class = cls_of(int'(v.pat), n);
      start        = v.noise && (n == 100);
      acc          = vld && bif.in_ready;
      @(negedge clk);
      cyc++;
      if (acc) n++;
      if (n < NP && (done || !bif.in_ready)) early++;
    end
    bif.in_valid = 1'b0;
    start        = 1'b0;
    check({tag, "_beats_accepted"}, n, NP);
    check({tag, "_no_early_done"}, early, 0);
    check({tag, "_done_cycle"}, {done, busy, bif.in_ready}, 3'b100);
    check({tag, "_counts"}, packed_counts(), v.exp);
    // start during DONE must be ignored
    start = v.noise;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_pulse_end"}, {done, busy, bif.in_ready}, 3'b000);
    repeat (3) @(negedge clk);
    check({tag, "_hold_idle"}, {packed_counts(), done, busy}, {v.exp, 2'b00});
  endtask

  initial begin
    // Image table: pattern, valid gaps, stray start pulses, expected counts.
    for (int i = 0; i < 6; i++) vecs[i] = '0;
    vecs[0].pat = 3'd0;
    vecs[1].pat = 3'd1;
    for (int c = 0; c < NC; c++) vecs[1].exp[c] = (c < 4) ? 8'd61 : 8'd60;
    vecs[2].pat = 3'd2;
    vecs[2].exp[5] = 8'd255;
    vecs[3].pat = 3'd3; vecs[3].gaps = 1'b1;
    vecs[4].pat = 3'd4; vecs[4].gaps = 1'b1; vecs[4].noise = 1'b1;
    for (int c = 1; c < NC; c += 2) vecs[4].exp[c] = 8'd49;
    vecs[5].pat = 3'd5; vecs[5].noise = 1'b1;
    vecs[5].exp[0] = 8'd255;

    rst = 1'b1; start = 1'b0;
    bif.in_valid = 1'b0; bif.in_pixel = 1'b0; bif.in_class = '0;
    repeat (2) @(negedge clk);
    check("reset_state", {packed_counts(), busy, done, bif.in_ready}, '0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {busy, done, bif.in_ready}, 3'b000);

    for (int i = 0; i < 6; i++) run_image(vecs[i], i);

    // Mid-image reset: 400 active class-2 beats then asynchronous reset.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bif.in_valid = 1'b1; bif.in_pixel = 1'b1; bif.in_class = 4'd2;
      @(negedge clk);
    end
    check("pre_abort_count2", counts[2], 8'd255);
    check("pre_abort_busy", {busy, bif.in_ready}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", {packed_counts(), busy, done, bif.in_ready}, '0);
    bif.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen_done;
      seen_done = 0;
      repeat (5) begin
        @(negedge clk);
        if (done || busy) seen_done++;
      end
      check("no_done_after_abort", seen_done, 0);
    end
    run_image(vecs[1], 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
